// File: rtl/mem_sync_array.sv
// Single-port synchronous word memory with registered read/write-echo output
// and a hardware clear sweep that zeroes one word per cycle after reset or on request.
module mem_sync_array #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              select,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              clear,
  output logic [WIDTH-1:0]  data_out,
  output logic              valid,
  output logic              ready,
  output logic              err
);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              accept, in_range, last;

  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (last)  state_nxt = S_IDLE;
      S_IDLE:  if (clear) state_nxt = S_CLEAR;
      default:            state_nxt = S_CLEAR;
    endcase
  end

  // clear has priority over a request presented in the same cycle
  always_comb begin
    ready    = (state == S_IDLE);
    accept   = ready && select && !clear;
    in_range = ({1'b0, address} < DEPTH_EXT);
    last     = (cnt == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (state == S_CLEAR) cnt <= last ? '0 : cnt + 1'b1;
    else if (clear)           cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR)                   mem[cnt]     <= '0;
      else if (accept && in_range && !rw)     mem[address] <= data_in;
    end
  end

  // output stage: read data or write echo, one edge after the request
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (accept) begin
        if (in_range) begin
          valid    <= 1'b1;
          data_out <= rw ? mem[address] : data_in;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_sync_array.sv
// Scoreboard bench for mem_sync_array: a default 8x8 instance and a 5x12 instance
// exercising the non-power-of-two depth and out-of-range error path.
module tb_mem_sync_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_err;
    logic [11:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  logic       rst0, sel0, rw0, clr0, vld0, rdy0, err0;
  logic [2:0] addr0;
  logic [7:0] din0, dout0;

  logic        rst1, sel1, rw1, clr1, vld1, rdy1, err1;
  logic [2:0]  addr1;
  logic [11:0] din1, dout1;

  mem_sync_array #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) u0 (
    .clk(clk), .rst(rst0), .select(sel0), .rw(rw0), .address(addr0),
    .data_in(din0), .clear(clr0), .data_out(dout0), .valid(vld0),
    .ready(rdy0), .err(err0)
  );

  mem_sync_array #(.WIDTH(12), .DEPTH(5), .ADDR_W(3)) u1 (
    .clk(clk), .rst(rst1), .select(sel1), .rw(rw1), .address(addr1),
    .data_in(din1), .clear(clr1), .data_out(dout1), .valid(vld1),
    .ready(rdy1), .err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vld0 === 1'b1 || err0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_output", {30'b0, vld0, err0}, 32'h0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_err_flag", {31'b0, err0}, {31'b0, e0.is_err});
        chk("dut0_valid_flag", {31'b0, vld0}, {31'b0, !e0.is_err});
        if (!e0.is_err) chk("dut0_data", {24'b0, dout0}, {24'b0, e0.data[7:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (vld1 === 1'b1 || err1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_output", {30'b0, vld1, err1}, 32'h0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_err_flag", {31'b0, err1}, {31'b0, e1.is_err});
        chk("dut1_valid_flag", {31'b0, vld1}, {31'b0, !e1.is_err});
        if (!e1.is_err) chk("dut1_data", {20'b0, dout1}, {20'b0, e1.data});
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic r, input logic [2:0] a, input logic [7:0] d,
                      input logic x_err, input logic [7:0] x_data);
    exp_t e;
    e.is_err = x_err;
    e.data   = {4'h0, x_data};
    sel0 = 1'b1; rw0 = r; addr0 = a; din0 = d;
    q0.push_back(e);
    step();
    sel0 = 1'b0;
  endtask

  task automatic req1(input logic r, input logic [2:0] a, input logic [11:0] d,
                      input logic x_err, input logic [11:0] x_data);
    exp_t e;
    e.is_err = x_err;
    e.data   = x_data;
    sel1 = 1'b1; rw1 = r; addr1 = a; din1 = d;
    q1.push_back(e);
    step();
    sel1 = 1'b0;
  endtask

  task automatic sweep0(input int n, input logic chk_out);
    for (int i = 0; i < n; i++) begin
      chk("dut0_ready_low", {31'b0, rdy0}, 32'h0);
      if (chk_out) begin
        chk("dut0_dout_zero", {24'b0, dout0}, 32'h0);
        chk("dut0_valid_low", {31'b0, vld0}, 32'h0);
      end
      step();
    end
    chk("dut0_ready_high", {31'b0, rdy0}, 32'h1);
  endtask

  task automatic sweep1(input int n, input logic chk_out);
    for (int i = 0; i < n; i++) begin
      chk("dut1_ready_low", {31'b0, rdy1}, 32'h0);
      if (chk_out) begin
        chk("dut1_dout_zero", {20'b0, dout1}, 32'h0);
        chk("dut1_valid_low", {31'b0, vld1}, 32'h0);
      end
      step();
    end
    chk("dut1_ready_high", {31'b0, rdy1}, 32'h1);
  endtask

  initial begin
    rst0 = 1'b1; sel0 = 1'b0; rw0 = 1'b0; clr0 = 1'b0; addr0 = '0; din0 = '0;
    rst1 = 1'b1; sel1 = 1'b0; rw1 = 1'b0; clr1 = 1'b0; addr1 = '0; din1 = '0;

    // reset for two edges, then an 8-cycle sweep
    step(); step();
    rst0 = 1'b0;
    sweep0(8, 1'b1);
    for (int a = 0; a < 8; a++) req0(1'b1, 3'(a), 8'h00, 1'b0, 8'h00);

    // write echo and read back
    req0(1'b0, 3'd3, 8'hA5, 1'b0, 8'hA5);
    req0(1'b0, 3'd7, 8'h5A, 1'b0, 8'h5A);
    req0(1'b1, 3'd3, 8'h00, 1'b0, 8'hA5);
    req0(1'b1, 3'd7, 8'h00, 1'b0, 8'h5A);

    // back-to-back write then read, then an idle cycle holds data_out
    req0(1'b0, 3'd2, 8'h11, 1'b0, 8'h11);
    req0(1'b1, 3'd2, 8'h00, 1'b0, 8'h11);
    step();
    chk("dut0_hold_idle", {24'b0, dout0}, 32'h11);

    // fill with 0xFF, then clear with a simultaneous read that must be ignored
    for (int a = 0; a < 8; a++) req0(1'b0, 3'(a), 8'hFF, 1'b0, 8'hFF);
    clr0 = 1'b1; sel0 = 1'b1; rw0 = 1'b1; addr0 = 3'd0;
    step();
    clr0 = 1'b0; sel0 = 1'b1; rw0 = 1'b0; addr0 = 3'd0; din0 = 8'h77;
    sweep0(8, 1'b0);
    sel0 = 1'b0;
    for (int a = 0; a < 8; a++) req0(1'b1, 3'(a), 8'h00, 1'b0, 8'h00);

    // reset on the third sweep cycle restarts the sweep
    req0(1'b0, 3'd1, 8'h3C, 1'b0, 8'h3C);
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    step(); step();
    rst0 = 1'b1;
    step();
    chk("dut0_dout_after_rst", {24'b0, dout0}, 32'h0);
    rst0 = 1'b0;
    sweep0(8, 1'b0);
    req0(1'b1, 3'd1, 8'h00, 1'b0, 8'h00);

    // non-power-of-two instance
    rst1 = 1'b0;
    sweep1(5, 1'b1);
    req1(1'b0, 3'd4, 12'hABC, 1'b0, 12'hABC);
    req1(1'b1, 3'd4, 12'h000, 1'b0, 12'hABC);
    req1(1'b0, 3'd6, 12'h123, 1'b1, 12'h000);
    chk("dut1_err_hold", {20'b0, dout1}, 32'hABC);
    req1(1'b1, 3'd4, 12'h000, 1'b0, 12'hABC);
    req1(1'b1, 3'd5, 12'h000, 1'b1, 12'h000);
    req1(1'b1, 3'd0, 12'h000, 1'b0, 12'h000);

    step(); step();
    chk("dut0_queue_empty", 32'(q0.size()), 32'h0);
    chk("dut1_queue_empty", 32'(q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
